// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, state encodings and the RUN-state rule table for pipeline_ctrl.
package pipeline_ctrl_pkg;

    // Sequencer state; plain vector constants keep older tools happy.
    typedef logic [1:0] pipe_ctrl_state_t;
    localparam pipe_ctrl_state_t PC_RUN       = 2'd0;
    localparam pipe_ctrl_state_t PC_DMEM_WAIT = 2'd1;
    localparam pipe_ctrl_state_t PC_SQUASH    = 2'd2;

    // One cycle's worth of pipeline register enables.
    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic pc_redirect;
    } pipe_ctrl_en_t;

    localparam pipe_ctrl_en_t EN_FREEZE = pipe_ctrl_en_t'(8'b00000_000);
    localparam pipe_ctrl_en_t EN_ALL    = pipe_ctrl_en_t'(8'b11111_000);
    // Wrong-path fetch in flight: hold PC, bubble whatever IF/ID receives.
    localparam pipe_ctrl_en_t EN_SQUASH = pipe_ctrl_en_t'(8'b01111_100);

    // Priority rules 2..6 of the RUN state, evaluated with no memory stall.
    function automatic pipe_ctrl_en_t run_rules(logic br, logic busy, logic lu);
        pipe_ctrl_en_t en;
        en = EN_ALL;
        if (br) begin
            en.pc_redirect = 1'b1;
            en.flush_id_ex = 1'b1;
            // A busy fetch is wrong-path; IF/ID holds and the squash state cleans up.
            if (busy) en.load_if_id  = 1'b0;
            else      en.flush_if_id = 1'b1;
        end else if (lu) begin
            en.load_pc     = 1'b0;
            en.load_if_id  = 1'b0;
            en.flush_id_ex = 1'b1;
        end else if (busy) begin
            en.load_pc     = 1'b0;
            en.flush_if_id = 1'b1;
        end
        return en;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, register enables and perf counters between pipeline_ctrl and the datapath.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_busy_i;
    logic             dmem_req_i;
    logic             dmem_resp_i;
    logic             load_use_i;
    logic             br_mispredict_i;
    logic             load_pc_o;
    logic             load_if_id_o;
    logic             load_id_ex_o;
    logic             load_ex_mem_o;
    logic             load_mem_wb_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             pc_redirect_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Controller side.
    modport master (
        input  imem_busy_i, dmem_req_i, dmem_resp_i, load_use_i, br_mispredict_i,
        output load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o,
        output flush_if_id_o, flush_id_ex_o, pc_redirect_o, stall_cnt_o, flush_cnt_o
    );

    // Datapath side.
    modport slave (
        output imem_busy_i, dmem_req_i, dmem_resp_i, load_use_i, br_mispredict_i,
        input  load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o,
        input  flush_if_id_o, flush_id_ex_o, pc_redirect_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    // Count enabled cycles, holding at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, load-use, redirects, squash.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.master bus
);
    pipe_ctrl_state_t state_q;
    pipe_ctrl_state_t state_d;
    pipe_ctrl_en_t    en;
    logic             mem_stall;
    logic             br_busy;

    // Next-state and enable decode; all enables forced low while reset is held.
    always_comb begin
        mem_stall = bus.dmem_req_i & ~bus.dmem_resp_i;
        br_busy   = bus.br_mispredict_i & bus.imem_busy_i;
        state_d   = state_q;
        en        = EN_FREEZE;
        case (state_q)
            PC_RUN: begin
                if (mem_stall) begin
                    state_d = PC_DMEM_WAIT;
                end else begin
                    en = run_rules(bus.br_mispredict_i, bus.imem_busy_i, bus.load_use_i);
                    if (br_busy) state_d = PC_SQUASH;
                end
            end
            PC_DMEM_WAIT: begin
                // Frozen until the response; a held mispredict is serviced on that cycle.
                if (bus.dmem_resp_i) begin
                    en      = run_rules(bus.br_mispredict_i, bus.imem_busy_i, bus.load_use_i);
                    state_d = br_busy ? PC_SQUASH : PC_RUN;
                end
            end
            PC_SQUASH: begin
                // PC already holds the target; new mispredicts here are wrong-path.
                if (!mem_stall) begin
                    en = EN_SQUASH;
                    if (!bus.imem_busy_i) state_d = PC_RUN;
                end
            end
            default: state_d = PC_RUN;
        endcase
        if (!rst) en = EN_FREEZE;
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.load_pc_o     = en.load_pc;
    assign bus.load_if_id_o  = en.load_if_id;
    assign bus.load_id_ex_o  = en.load_id_ex;
    assign bus.load_ex_mem_o = en.load_ex_mem;
    assign bus.load_mem_wb_o = en.load_mem_wb;
    assign bus.flush_if_id_o = en.flush_if_id;
    assign bus.flush_id_ex_o = en.flush_id_ex;
    assign bus.pc_redirect_o = en.pc_redirect;

    pipeline_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~en.load_pc),
        .count (bus.stall_cnt_o)
    );

    pipeline_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (en.pc_redirect),
        .count (bus.flush_cnt_o)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a rule-table reference model.
module tb_pipeline_ctrl;
    // Expected enable vectors: {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex, redir}
    localparam logic [7:0] ALL        = 8'b11111_000;
    localparam logic [7:0] FRZ        = 8'b00000_000;
    localparam logic [7:0] REDIR      = 8'b11111_111;
    localparam logic [7:0] REDIR_BUSY = 8'b10111_011;
    localparam logic [7:0] LU         = 8'b00111_010;
    localparam logic [7:0] FETCH      = 8'b01111_100;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(4))  sbus ();

    pipeline_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    pipeline_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .rst(rst_s), .bus(sbus));

    int tests = 0;
    int fails = 0;

    logic [7:0] got;
    assign got = {bus.load_pc_o, bus.load_if_id_o, bus.load_id_ex_o, bus.load_ex_mem_o,
                  bus.load_mem_wb_o, bus.flush_if_id_o, bus.flush_id_ex_o, bus.pc_redirect_o};

    // Reference model state: waiting on data memory, or discarding a wrong-path fetch.
    bit      m_wait;
    bit      m_sq;
    longint  m_stall;
    longint  m_flush;

    task automatic set_in(input logic req, resp, lu, br, busy);
        bus.dmem_req_i      = req;
        bus.dmem_resp_i     = resp;
        bus.load_use_i      = lu;
        bus.br_mispredict_i = br;
        bus.imem_busy_i     = busy;
    endtask

    task automatic drive(input logic req, resp, lu, br, busy);
        @(negedge clk);
        set_in(req, resp, lu, br, busy);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] model_out(logic req, resp, lu, br, busy);
        logic stall_mem = req & !resp;
        if (m_sq) return stall_mem ? FRZ : FETCH;
        if (m_wait ? !resp : stall_mem) return FRZ;
        if (br) return busy ? REDIR_BUSY : REDIR;
        if (lu) return LU;
        if (busy) return FETCH;
        return ALL;
    endfunction

    task automatic test_reset();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        set_in(1, 1, 0, 1, 0);
        rst = 1'b0;
        #1;
        tests++;
        if (got !== FRZ) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", got, FRZ); end
        tests++;
        if (bus.stall_cnt_o !== 0 || bus.flush_cnt_o !== 0) begin
            fails++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.flush_cnt_o);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        tests++;
        if (got !== ALL) begin fails++; $display("FAIL reset_run got=%b exp=%b", got, ALL); end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (bus.stall_cnt_o !== 0) begin
            fails++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt_o);
        end
    endtask

    task automatic test_dmem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            tests++;
            if (got !== FRZ) begin fails++; $display("FAIL dmem_wait_%0d got=%b exp=%b", i, got, FRZ); end
        end
        drive(1, 1, 0, 0, 0);
        tests++;
        if (got !== ALL) begin fails++; $display("FAIL dmem_resp got=%b exp=%b", got, ALL); end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (bus.stall_cnt_o !== 3) begin
            fails++; $display("FAIL dmem_stall_cnt got=%0d exp=3", bus.stall_cnt_o);
        end
        drive(1, 1, 0, 0, 0);
        tests++;
        if (got !== ALL) begin fails++; $display("FAIL dmem_single got=%b exp=%b", got, ALL); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(0, 0, 1, 0, 0);
        tests++;
        if (got !== LU) begin fails++; $display("FAIL load_use got=%b exp=%b", got, LU); end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (got !== ALL || bus.stall_cnt_o !== 1) begin
            fails++;
            $display("FAIL load_use_after got=%b/%0d exp=%b/1", got, bus.stall_cnt_o, ALL);
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        drive(0, 0, 0, 1, 0);
        tests++;
        if (got !== REDIR) begin fails++; $display("FAIL mispredict got=%b exp=%b", got, REDIR); end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (got !== ALL || bus.flush_cnt_o !== 1) begin
            fails++;
            $display("FAIL mispredict_after got=%b/%0d exp=%b/1", got, bus.flush_cnt_o, ALL);
        end
    endtask

    task automatic test_squash();
        logic [7:0] exp_seq [5];
        logic [4:0] busy_seq;
        logic [4:0] br_seq;
        exp_seq  = '{REDIR_BUSY, FETCH, FETCH, FETCH, ALL};
        busy_seq = 5'b00111;
        br_seq   = 5'b00011;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, br_seq[i], busy_seq[i]);
            tests++;
            if (got !== exp_seq[i]) begin
                fails++; $display("FAIL squash_%0d got=%b exp=%b", i, got, exp_seq[i]);
            end
        end
        tests++;
        if (bus.flush_cnt_o !== 1 || bus.stall_cnt_o !== 3) begin
            fails++;
            $display("FAIL squash_cnts got=%0d/%0d exp=1/3", bus.flush_cnt_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_combined();
        apply_reset();
        drive(1, 0, 1, 1, 0);
        tests++;
        if (got !== FRZ) begin fails++; $display("FAIL combo_freeze got=%b exp=%b", got, FRZ); end
        drive(1, 0, 1, 1, 0);
        tests++;
        if (got !== FRZ) begin fails++; $display("FAIL combo_wait got=%b exp=%b", got, FRZ); end
        drive(1, 1, 1, 1, 0);
        tests++;
        if (got !== REDIR) begin fails++; $display("FAIL combo_resp got=%b exp=%b", got, REDIR); end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (got !== ALL || bus.flush_cnt_o !== 1 || bus.stall_cnt_o !== 2) begin
            fails++;
            $display("FAIL combo_after got=%b/%0d/%0d exp=%b/1/2", got, bus.flush_cnt_o,
                     bus.stall_cnt_o, ALL);
        end
    endtask

    task automatic test_random();
        logic       req, resp, lu, br, busy, stall_mem;
        logic [7:0] exp;
        apply_reset();
        m_wait  = 0;
        m_sq    = 0;
        m_stall = 0;
        m_flush = 0;
        for (int i = 0; i < 600; i++) begin
            req  = ($urandom_range(0, 3) == 0);
            resp = $urandom_range(0, 1) == 1;
            lu   = ($urandom_range(0, 4) == 0);
            br   = ($urandom_range(0, 4) == 0);
            busy = ($urandom_range(0, 9) < 3);
            drive(req, resp, lu, br, busy);
            exp = model_out(req, resp, lu, br, busy);
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL random_out cyc=%0d got=%b exp=%b", i, got, exp);
            end
            tests++;
            if (longint'(bus.stall_cnt_o) != m_stall || longint'(bus.flush_cnt_o) != m_flush) begin
                fails++;
                $display("FAIL random_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.stall_cnt_o,
                         bus.flush_cnt_o, m_stall, m_flush);
            end
            if (!exp[7]) m_stall++;
            if (exp[0])  m_flush++;
            stall_mem = req & !resp;
            if (m_sq) begin
                if (!stall_mem && !busy) m_sq = 0;
            end else if (m_wait) begin
                if (resp) begin
                    m_wait = 0;
                    m_sq   = br & busy;
                end
            end else if (stall_mem) begin
                m_wait = 1;
            end else begin
                m_sq = br & busy;
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        sbus.dmem_req_i      = 0;
        sbus.dmem_resp_i     = 0;
        sbus.load_use_i      = 0;
        sbus.br_mispredict_i = 0;
        sbus.imem_busy_i     = 1;
        rst_s = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (sbus.stall_cnt_o !== 4'd10) begin
            fails++; $display("FAIL sat_mid got=%0d exp=10", sbus.stall_cnt_o);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (sbus.stall_cnt_o !== 4'd15) begin
            fails++; $display("FAIL sat_hold got=%0d exp=15", sbus.stall_cnt_o);
        end
    endtask

    initial begin
        rst   = 1'b0;
        rst_s = 1'b0;
        set_in(0, 0, 0, 0, 0);
        sbus.dmem_req_i      = 0;
        sbus.dmem_resp_i     = 0;
        sbus.load_use_i      = 0;
        sbus.br_mispredict_i = 0;
        sbus.imem_busy_i     = 0;
        test_reset();
        test_dmem_wait();
        test_load_use();
        test_mispredict();
        test_squash();
        test_combined();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
